// File: rtl/ebpf_alu_pkg.sv
// Shared types and constants for the eBPF ALU adder.
// Provides the per-stage control bundle and a parameter sanity helper.
package ebpf_alu_pkg;

  localparam int EBPF_ALU32_W = 32;

  // Control carried alongside each pipeline stage.
  // c32 is the carry out of bit 31, needed for ALU32 flags.
  typedef struct packed {
    logic valid;
    logic alu32;
    logic carry;
    logic c32;
  } adder_stage_t;

  function automatic bit adder_params_ok(
    input int width,
    input int seg_width,
    input int tag_w
  );
    return (seg_width > 0) && (tag_w > 0) &&
           (width >= EBPF_ALU32_W) &&
           (EBPF_ALU32_W % seg_width == 0) &&
           (width % seg_width == 0);
  endfunction

endpackage

// File: rtl/ebpf_adder_segment.sv
// One carry-chain segment: sum/co = a + b + ci.
// Ports: a, b (W bits), ci -> sum (W bits), co.
module ebpf_adder_segment
  import ebpf_alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/ebpf_pipelined_adder.sv
// Pipelined eBPF add/sub, one SEG_WIDTH segment per stage.
// Ports: in_* valid/ready op + tag, flush, out_* result/flags/tag.
module ebpf_pipelined_adder
  import ebpf_alu_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int SEG_WIDTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_alu32,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = WIDTH / SEG_WIDTH;
  localparam int LAST   = STAGES - 1;
  // first segment lying entirely above bit 31
  localparam int SEG32  = EBPF_ALU32_W / SEG_WIDTH;

  if (!adder_params_ok(WIDTH, SEG_WIDTH, TAG_W)) begin : g_bad
    $error("ebpf_pipelined_adder: illegal WIDTH/SEG_WIDTH/TAG_W");
  end

  logic             stall;
  logic             zero_q;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] a_e;
  logic [WIDTH-1:0] b_e;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ALU32 drops upper operand bits; sub folds ~B in here.
  always_comb begin
    mask = '1;
    if (in_alu32) mask = mask >> (WIDTH - EBPF_ALU32_W);
  end

  assign a_e = in_a & mask;
  assign b_e = (in_sub ? ~in_b : in_b) & mask;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    adder_stage_t         ctl;
    adder_stage_t         ctl_nx;
    logic [WIDTH-1:0]     res;
    logic [WIDTH-1:0]     res_nx;
    logic [TAG_W-1:0]     tag;
    logic [TAG_W-1:0]     tag_nx;
    logic [SEG_WIDTH-1:0] sa;
    logic [SEG_WIDTH-1:0] sb;
    logic [SEG_WIDTH-1:0] sum;
    logic                 ci;
    logic                 co;

    ebpf_adder_segment #(.W(SEG_WIDTH)) u_seg (
      .a  (sa),
      .b  (sb),
      .ci (ci),
      .sum(sum),
      .co (co)
    );

    if (k == 0) begin : g_head
      assign sa     = a_e[SEG_WIDTH-1:0];
      assign sb     = b_e[SEG_WIDTH-1:0];
      assign ci     = in_sub;
      assign res_nx = WIDTH'(sum);
      assign tag_nx = in_tag;
      assign ctl_nx = '{
        valid: in_valid,
        alu32: in_alu32,
        carry: co,
        c32:   (SEG32 == 1) ? co : 1'b0
      };
    end else begin : g_body
      assign sa = g_st[k-1].g_skew.a_hi[SEG_WIDTH-1:0];
      assign sb = g_st[k-1].g_skew.b_hi[SEG_WIDTH-1:0];
      // an ALU32 op must not carry into bit 32
      assign ci = g_st[k-1].ctl.carry &
                  ~(g_st[k-1].ctl.alu32 && (k == SEG32));
      assign res_nx = g_st[k-1].res |
                      (WIDTH'(sum) << (k * SEG_WIDTH));
      assign tag_nx = g_st[k-1].tag;
      assign ctl_nx = '{
        valid: g_st[k-1].ctl.valid,
        alu32: g_st[k-1].ctl.alu32,
        carry: co,
        c32:   (k == SEG32 - 1) ? co : g_st[k-1].ctl.c32
      };
    end

    // skew: operand segments not yet consumed
    if (k < LAST) begin : g_skew
      localparam int HW = WIDTH - (k + 1) * SEG_WIDTH;
      logic [HW-1:0] a_hi;
      logic [HW-1:0] b_hi;
      logic [HW-1:0] a_src;
      logic [HW-1:0] b_src;

      if (k == 0) begin : g_src0
        assign a_src = a_e[WIDTH-1:SEG_WIDTH];
        assign b_src = b_e[WIDTH-1:SEG_WIDTH];
      end else begin : g_srcn
        assign a_src =
          g_st[k-1].g_skew.a_hi[HW+SEG_WIDTH-1:SEG_WIDTH];
        assign b_src =
          g_st[k-1].g_skew.b_hi[HW+SEG_WIDTH-1:SEG_WIDTH];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (!stall) begin
          a_hi <= a_src;
          b_hi <= b_src;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl <= '0;
        res <= '0;
        tag <= '0;
      end else begin
        if (!stall) begin
          ctl <= ctl_nx;
          res <= res_nx;
          tag <= tag_nx;
        end
        if (flush) ctl.valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else if (!stall) zero_q <= (g_st[LAST].res_nx == '0);
  end

  assign out_valid  = g_st[LAST].ctl.valid;
  assign out_result = g_st[LAST].res;
  assign out_tag    = g_st[LAST].tag;
  assign out_zero   = zero_q;
  assign out_carry  = g_st[LAST].ctl.alu32 ? g_st[LAST].ctl.c32
                                           : g_st[LAST].ctl.carry;

endmodule

// File: tb/tb_ebpf_pipelined_adder.sv
// Self-checking bench for ebpf_pipelined_adder.
// Queue model + per-cycle compare, plus literal directed checks.
module tb_ebpf_pipelined_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sub;
  logic        in_alu32;
  logic [3:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        out_carry;
  logic        out_zero;
  logic [3:0]  out_tag;

  ebpf_pipelined_adder #(
    .WIDTH(64), .SEG_WIDTH(16), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_alu32(in_alu32),
    .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        c;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  log_tag[$];
  logic [63:0] log_res[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_res;
  logic [3:0]  prev_tag;
  logic        pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1,
                          1'b0, 1'b1, 1'b1, 1'b0};

  function automatic exp_t model(
    input logic [63:0] a, input logic [63:0] b,
    input logic sub, input logic alu32, input logic [3:0] tag
  );
    exp_t        e;
    logic [64:0] s;
    logic [32:0] s32;
    if (alu32) begin
      if (sub) begin
        e.r = {32'h0, a[31:0] - b[31:0]};
        e.c = (a[31:0] >= b[31:0]);
      end else begin
        s32 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        e.r = {32'h0, s32[31:0]};
        e.c = s32[32];
      end
    end else begin
      if (sub) begin
        e.r = a - b;
        e.c = (a >= b);
      end else begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[63:0];
        e.c = s[64];
      end
    end
    e.z = (e.r == 64'h0);
    e.t = tag;
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // per-cycle compare, just before the rising edge
  always @(negedge clk) begin
    #4;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready),
          64'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", out_result, prev_res);
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: tag %0d, none expected",
                   out_tag);
        end else begin
          chk("m_result", out_result, q[0].r);
          chk("m_carry", 64'(out_carry), 64'(q[0].c));
          chk("m_zero", 64'(out_zero), 64'(q[0].z));
          chk("m_tag", 64'(out_tag), 64'(q[0].t));
          if (out_ready) begin
            log_tag.push_back(out_tag);
            log_res.push_back(out_result);
            void'(q.pop_front());
          end
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_res   = out_result;
      prev_tag   = out_tag;
      if (flush) q.delete();
      else if (in_valid && in_ready)
        q.push_back(model(in_a, in_b, in_sub, in_alu32, in_tag));
    end
  end

  // call right after a falling edge; returns at the falling
  // edge that follows the accepting rising edge
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic alu32,
                       input logic [3:0] tag);
    int n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_sub = sub;
    in_alu32 = alu32; in_tag = tag;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: tag %0d never accepted", tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // edges counted from the accept edge to out_valid
  task automatic await_result(output int edges);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic expect_out(input string name,
                            input logic [63:0] r, input logic c,
                            input logic z, input logic [3:0] t);
    int lat;
    await_result(lat);
    chk({name, "_latency"}, 64'(lat), 64'd4);
    chk({name, "_result"}, out_result, r);
    chk({name, "_carry"}, 64'(out_carry), 64'(c));
    chk({name, "_zero"}, 64'(out_zero), 64'(z));
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_result"}, out_result, 64'd0);
    chk({name, "_carry"}, 64'(out_carry), 64'd0);
    chk({name, "_zero"}, 64'(out_zero), 64'd0);
    chk({name, "_tag"}, 64'(out_tag), 64'd0);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_alu32 = 1'b0; in_tag = '0; flush = 1'b0;
    out_ready = 1'b1;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // carry propagation across all segments
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'hA);
    expect_out("t1", 64'h0, 1'b1, 1'b1, 4'hA);

    // ALU32
    issue(64'hDEAD_BEEF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 4'h1);
    expect_out("t2a", 64'h0, 1'b1, 1'b1, 4'h1);
    issue(64'h1_0000_0005, 64'h2, 1'b0, 1'b1, 4'h2);
    expect_out("t2b", 64'h7, 1'b0, 1'b0, 4'h2);

    // subtract
    issue(64'd5, 64'd7, 1'b1, 1'b0, 4'h3);
    expect_out("t3a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'h3);
    issue(64'd7, 64'd5, 1'b1, 1'b0, 4'h4);
    expect_out("t3b", 64'h2, 1'b1, 1'b0, 4'h4);
    issue(64'd9, 64'd9, 1'b1, 1'b1, 4'h5);
    expect_out("t3c", 64'h0, 1'b1, 1'b1, 4'h5);
    @(negedge clk);

    // backpressure
    log_tag.delete();
    log_res.delete();
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(64'(i), 64'(i) << 40, 1'b0, 1'b0, 4'(i));
      end
      begin
        for (int c = 0; c < 80 && log_tag.size() < 8; c++) begin
          out_ready = pat[c % 8];
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    chk("bp_count", 64'(log_tag.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_tag.size(); i++) begin
      chk("bp_tag", 64'(log_tag[i]), 64'(i));
      chk("bp_result", log_res[i], (64'(i) << 40) | 64'(i));
    end

    // flush with a 4th op presented in the flush cycle
    @(negedge clk);
    base = log_tag.size();
    for (int i = 1; i <= 3; i++)
      issue(64'(100 + i), 64'h1, 1'b0, 1'b0, 4'(i));
    in_valid = 1'b1; in_a = 64'd50; in_b = 64'd1;
    in_tag = 4'h4; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    issue(64'h0000_1234_0000_0000, 64'h0000_0001_0000_0001,
          1'b0, 1'b0, 4'h5);
    expect_out("t5", 64'h0000_1235_0000_0001, 1'b0, 1'b0, 4'h5);
    @(negedge clk);
    chk("t5_outs", 64'(log_tag.size() - base), 64'd1);
    if (log_tag.size() > 0)
      chk("t5_last", 64'(log_tag[log_tag.size()-1]), 64'd5);

    // asynchronous reset with the pipe full
    for (int i = 1; i <= 4; i++)
      issue(64'(i), 64'(i), 1'b0, 1'b0, 4'(i));
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    base = log_tag.size();
    issue(64'd40, 64'd2, 1'b0, 1'b0, 4'h9);
    expect_out("t6", 64'd42, 1'b0, 1'b0, 4'h9);
    repeat (8) @(negedge clk);
    chk("t6_outs", 64'(log_tag.size() - base), 64'd1);
    chk("t6_idle", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
